alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an external combinational 4-bit ALU: accepts a command,
// holds the operands stable for SETTLE_CYCLES, captures the result and hands it back.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic       cmd_cin,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_main_sel,
  output logic [1:0] alu_sub_sel,
  output logic       alu_cin,
  input  logic [3:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       rsp_zero,
  output logic [3:0] acc
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] acc_q;
  logic [3:0] rsp_data_q;
  logic       rsp_zero_q;
  logic       rsp_valid_q;
  logic       cmd_ready_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [1:0] alu_main_sel_q;
  logic [1:0] alu_sub_sel_q;
  logic       alu_cin_q;
  logic [3:0] alu_a_d;

  // acc_q here is the value at the acceptance edge, including a just-captured result
  assign alu_a_d = cmd_use_acc ? acc_q : cmd_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      acc_q          <= 4'd0;
      rsp_data_q     <= 4'd0;
      rsp_zero_q     <= 1'b1;
      rsp_valid_q    <= 1'b0;
      cmd_ready_q    <= 1'b1;
      alu_a_q        <= 4'd0;
      alu_b_q        <= 4'd0;
      alu_main_sel_q <= 2'd0;
      alu_sub_sel_q  <= 2'd0;
      alu_cin_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_a_q        <= alu_a_d;
            alu_b_q        <= cmd_b;
            alu_main_sel_q <= cmd_op[3:2];
            alu_sub_sel_q  <= cmd_op[1:0];
            alu_cin_q      <= cmd_cin;
            cnt_q          <= SETTLE_LD;
            cmd_ready_q    <= 1'b0;
            state_q        <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == 4'd1) begin
            rsp_data_q  <= alu_result;
            rsp_zero_q  <= (alu_result == 4'd0);
            acc_q       <= alu_result;
            rsp_valid_q <= 1'b1;
            cnt_q       <= 4'd0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_zero     = rsp_zero_q;
  assign acc          = acc_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_main_sel = alu_main_sel_q;
  assign alu_sub_sel  = alu_sub_sel_q;
  assign alu_cin      = alu_cin_q;

endmodule
